// File: rtl/adc_pkt_pkg.sv
// Shared constants and state encoding for the ADC frame packer.
package adc_pkt_pkg;
    localparam logic [7:0] SYNC0     = 8'hA5;
    localparam logic [7:0] SYNC1     = 8'h5A;
    localparam int         HDR_BYTES = 4;

    typedef enum logic [1:0] {IDLE, HDR, DATA, PAD} state_t;
endpackage

// File: rtl/adc_frame_packer_if.sv
// Sample input and capture-FIFO write bus of the frame packer.
interface adc_frame_packer_if;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       fifo_full;
    logic [7:0] fifo_din;
    logic       fifo_wr_en;

    modport master (output sample_valid, sample_data, fifo_full,
                    input  fifo_din, fifo_wr_en);
    modport slave  (input  sample_valid, sample_data, fifo_full,
                    output fifo_din, fifo_wr_en);
endinterface

// File: rtl/sample_skid_fifo.sv
// Small synchronous FIFO with first-word-fall-through output for holding samples.
module sample_skid_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A pop in the same cycle frees the slot, so a push on full is still taken.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
endmodule

// File: rtl/adc_frame_packer.sv
// Packs 8-bit ADC samples into fixed-length frames (sync word + sequence header,
// samples, zero padding) and writes them to the capture FIFO under backpressure.
module adc_frame_packer
    import adc_pkt_pkg::*;
#(
    parameter int FRAME_BYTES = 1024,
    parameter int SKID_DEPTH  = 8
) (
    input  logic              clk_32,
    input  logic              rst_n,
    input  logic              capture_en,
    adc_frame_packer_if.slave link,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic              overflow
);
    localparam int            CW       = $clog2(FRAME_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BYTES - 1);
    localparam logic [CW-1:0] HDR_LAST = CW'(HDR_BYTES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] byte_idx;
    logic [15:0]   seq;
    logic [15:0]   frames;
    logic          cap_q;
    logic          session_start;
    logic          byte_avail;
    logic          wr;
    logic          frame_end;
    logic          push_req;
    logic          skid_pop;
    logic          skid_full;
    logic          skid_empty;
    logic          drop;
    logic [7:0]    skid_dout;
    logic [7:0]    byte_mux;

    assign session_start = (state == IDLE) & capture_en & ~cap_q;
    assign byte_avail    = (state == HDR) | (state == PAD) | ((state == DATA) & ~skid_empty);
    assign wr            = byte_avail & ~link.fifo_full;
    assign frame_end     = wr & (byte_idx == LAST_IDX);
    assign skid_pop      = wr & (state == DATA);
    assign push_req      = link.sample_valid & capture_en & (state != IDLE);
    assign drop          = push_req & skid_full & ~skid_pop;

    assign link.fifo_wr_en = wr;
    assign link.fifo_din   = byte_mux;
    assign busy            = (state != IDLE);
    assign frame_cnt       = frames;

    sample_skid_fifo #(
        .DATA_W (8),
        .DEPTH  (SKID_DEPTH)
    ) u_skid (
        .clk   (clk_32),
        .rst_n (rst_n),
        .clr   (session_start),
        .push  (push_req),
        .pop   (skid_pop),
        .din   (link.sample_data),
        .dout  (skid_dout),
        .full  (skid_full),
        .empty (skid_empty)
    );

    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        byte_mux  = 8'h00;
        unique case (state)
            IDLE: if (session_start) state_nxt = HDR;
            HDR: begin
                unique case (byte_idx[1:0])
                    2'd0:    byte_mux = SYNC0;
                    2'd1:    byte_mux = SYNC1;
                    2'd2:    byte_mux = seq[15:8];
                    default: byte_mux = seq[7:0];
                endcase
                if (wr && byte_idx == HDR_LAST) state_nxt = DATA;
            end
            DATA: begin
                byte_mux = skid_dout;
                if (frame_end)                      state_nxt = capture_en ? HDR : IDLE;
                else if (~capture_en & skid_empty)  state_nxt = PAD;
            end
            PAD: if (frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Statistics are cleared only when a new session starts, so they stay readable in IDLE.
    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            cap_q    <= 1'b0;
            seq      <= 16'd0;
            frames   <= 16'd0;
            drop_cnt <= 16'd0;
            overflow <= 1'b0;
        end else begin
            cap_q <= capture_en;
            if (session_start) begin
                byte_idx <= '0;
                seq      <= 16'd0;
                frames   <= 16'd0;
                drop_cnt <= 16'd0;
                overflow <= 1'b0;
            end else begin
                if (wr) byte_idx <= frame_end ? '0 : byte_idx + 1'b1;
                if (frame_end) begin
                    seq    <= seq + 16'd1;
                    frames <= frames + 16'd1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_frame_packer.sv
// Randomized and directed bench for adc_frame_packer against a frame-level reference model.
module tb_adc_frame_packer;
    localparam int FB = 16;
    localparam int SD = 8;

    logic        clk_32 = 1'b0;
    logic        rst_n;
    logic        capture_en;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    adc_frame_packer_if link();

    adc_frame_packer #(.FRAME_BYTES(FB), .SKID_DEPTH(SD)) dut (
        .clk_32     (clk_32),
        .rst_n      (rst_n),
        .capture_en (capture_en),
        .link       (link),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    always #5 clk_32 = ~clk_32;

    // Reference model: session flag, position inside the frame, padding flag, sample queue.
    bit          m_busy;
    bit          m_pad;
    int          m_pos;
    logic [7:0]  m_skid[$];
    logic [15:0] m_seq;
    logic [15:0] m_fc;
    logic [15:0] m_dc;
    bit          m_ovf;
    bit          m_cap_prev;

    logic [7:0]  log_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] getb(input int idx);
        if (idx < log_q.size()) return log_q[idx];
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_pad = 0; m_pos = 0; m_skid.delete();
        m_seq = 16'd0; m_fc = 16'd0; m_dc = 16'd0; m_ovf = 0; m_cap_prev = 0;
    endtask

    task automatic drive(input logic c, input logic v, input logic [7:0] d, input logic f);
        capture_en = c; link.sample_valid = v; link.sample_data = d; link.fifo_full = f;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        bit         e_av;
        bit         e_wr;
        logic [7:0] e_din;
        int         sz0;
        @(negedge clk_32);
        if (!rst_n) begin
            model_reset();
            chk("rst_wr_en", 32'(link.fifo_wr_en), 0);
            chk("rst_din", 32'(link.fifo_din), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_frames", 32'(frame_cnt), 0);
            chk("rst_drops", 32'(drop_cnt), 0);
            chk("rst_overflow", 32'(overflow), 0);
        end else begin
            e_av = 0; e_din = 8'h00;
            if (m_busy) begin
                if (m_pos < 4) begin
                    e_av = 1;
                    case (m_pos)
                        0:       e_din = 8'hA5;
                        1:       e_din = 8'h5A;
                        2:       e_din = m_seq[15:8];
                        default: e_din = m_seq[7:0];
                    endcase
                end else if (m_pad) begin
                    e_av = 1;
                end else if (m_skid.size() > 0) begin
                    e_av = 1; e_din = m_skid[0];
                end
            end
            e_wr = e_av & ~link.fifo_full;
            chk("wr_en", 32'(link.fifo_wr_en), 32'(e_wr));
            if (e_wr && link.fifo_wr_en) chk("din", 32'(link.fifo_din), 32'(e_din));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_dc));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (link.fifo_wr_en) log_q.push_back(link.fifo_din);

            sz0 = m_skid.size();
            if (m_busy) begin
                if (e_wr && m_pos >= 4 && !m_pad) void'(m_skid.pop_front());
                if (link.sample_valid && capture_en) begin
                    if (m_skid.size() < SD) m_skid.push_back(link.sample_data);
                    else begin
                        m_ovf = 1;
                        if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
                    end
                end
                if (e_wr) begin
                    if (m_pos == FB - 1) begin
                        m_seq = m_seq + 16'd1; m_fc = m_fc + 16'd1; m_pos = 0;
                        if (m_pad || !capture_en) m_busy = 0;
                        m_pad = 0;
                    end else m_pos++;
                end else if (m_pos >= 4 && !m_pad && sz0 == 0 && !capture_en) m_pad = 1;
            end else if (capture_en && !m_cap_prev) begin
                m_busy = 1; m_pos = 0; m_pad = 0; m_skid.delete();
                m_seq = 16'd0; m_fc = 16'd0; m_dc = 16'd0; m_ovf = 0;
            end
            m_cap_prev = capture_en;
        end
        @(posedge clk_32); #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        drive(0, 0, 8'h00, 0);
        while (busy && n < max_cycles) begin step(); n++; end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic chk_hdr(input string name, input int base, input logic [15:0] s);
        chk(name, 32'(getb(base)), 'hA5);
        chk(name, 32'(getb(base + 1)), 'h5A);
        chk(name, 32'(getb(base + 2)), 32'(s[15:8]));
        chk(name, 32'(getb(base + 3)), 32'(s[7:0]));
    endtask

    initial begin
        int mark;
        int dens;
        int fp;
        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 8'h00, 0);
        repeat (2) @(posedge clk_32);
        #1;
        step();
        rst_n = 1'b1;
        step();

        // Continuous samples 01.. with capture_en high for 40 cycles.
        mark = log_q.size();
        drive(1, 0, 8'h00, 0); step();
        for (int i = 1; i <= 39; i++) begin
            drive(1, 1, 8'(i), 0); step();
            if (i == 20) chk("t1_no_drop_before_saturation", 32'(drop_cnt), 0);
        end
        chk("t1_drops_after_saturation", 32'(drop_cnt), 4);
        chk("t1_overflow", 32'(overflow), 1);
        wait_idle(200);
        chk("t1_len", 32'(log_q.size() - mark >= 2 * FB), 1);
        chk_hdr("t1_hdr0", mark, 16'h0000);
        for (int i = 0; i < 12; i++) chk("t1_data", 32'(getb(mark + 4 + i)), 32'(i + 1));
        chk_hdr("t1_hdr1", mark + FB, 16'h0001);

        // Samples every second cycle, capture_en drops after the fifth.
        mark = log_q.size();
        drive(1, 0, 8'h00, 0); step();
        for (int k = 1; k <= 5; k++) begin
            drive(1, 1, 8'(k), 0); step();
            if (k < 5) begin drive(1, 0, 8'h00, 0); step(); end
        end
        wait_idle(200);
        chk("t2_len", 32'(log_q.size() - mark), FB);
        chk_hdr("t2_hdr", mark, 16'h0000);
        for (int k = 0; k < 5; k++) chk("t2_data", 32'(getb(mark + 4 + k)), 32'(k + 1));
        for (int k = 9; k < FB; k++) chk("t2_pad", 32'(getb(mark + k)), 0);
        chk("t2_frames", 32'(frame_cnt), 1);

        // FIFO full for 20 cycles in the middle of DATA.
        drive(1, 0, 8'h00, 0); step();
        for (int i = 1; i <= 9; i++) begin drive(1, 1, 8'(100 + i), 0); step(); end
        for (int i = 10; i <= 29; i++) begin
            drive(1, 1, 8'(100 + i), 1); step();
        end
        chk("t3_drops", 32'(drop_cnt), 16);
        chk("t3_overflow", 32'(overflow), 1);
        for (int i = 30; i <= 49; i++) begin drive(1, 1, 8'(100 + i), 0); step(); end
        wait_idle(200);

        // One-cycle capture_en pulse: header then pure padding.
        mark = log_q.size();
        drive(1, 0, 8'h00, 0); step();
        wait_idle(200);
        chk("t4_len", 32'(log_q.size() - mark), FB);
        chk_hdr("t4_hdr", mark, 16'h0000);
        for (int k = 4; k < FB; k++) chk("t4_pad", 32'(getb(mark + k)), 0);

        // Asynchronous reset in the second frame of a session.
        drive(1, 0, 8'h00, 0); step();
        for (int i = 1; i <= 24; i++) begin drive(1, 1, 8'(i * 3), 0); step(); end
        chk("t5_pre_frames", 32'(frame_cnt), 1);
        drive(0, 0, 8'h00, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_async_wr_en", 32'(link.fifo_wr_en), 0);
        chk("t5_async_busy", 32'(busy), 0);
        chk("t5_async_frames", 32'(frame_cnt), 0);
        chk("t5_async_din", 32'(link.fifo_din), 0);
        step();
        rst_n = 1'b1;
        step();
        mark = log_q.size();
        drive(1, 0, 8'h00, 0); step();
        for (int i = 0; i < 6; i++) step();
        wait_idle(200);
        chk_hdr("t5_restart_hdr", mark, 16'h0000);

        // Sequence wrap: preload seq/frame count near 0xFFFF during an active session.
        drive(1, 0, 8'h00, 0); step();
        for (int i = 0; i < 5; i++) step();
        force dut.seq = 16'hFFFE;
        force dut.frames = 16'hFFFE;
        m_seq = 16'hFFFE;
        m_fc = 16'hFFFE;
        step();
        release dut.seq;
        release dut.frames;
        mark = log_q.size();
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 8'(200 + i), 0); step();
            if (i == 30) chk("t6_frames_wrap", 32'(frame_cnt), 0);
        end
        wait_idle(200);
        chk_hdr("t6_hdr_ffff", mark + 12, 16'hFFFF);
        chk_hdr("t6_hdr_0000", mark + 12 + FB, 16'h0000);

        // Randomized sessions with random density, backpressure and capture_en glitches.
        for (int s = 0; s < 40; s++) begin
            dens = $urandom_range(100);
            fp   = $urandom_range(40);
            drive(1, 0, 8'h00, 0); step();
            for (int i = 0; i < $urandom_range(80, 1); i++) begin
                drive(($urandom_range(15) != 0), ($urandom_range(99) < dens),
                      8'($urandom), ($urandom_range(99) < fp));
                step();
            end
            wait_idle(300);
            for (int i = 0; i < $urandom_range(3); i++) begin
                drive(0, 1, 8'($urandom), ($urandom_range(1) == 1)); step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
